ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register and operand-select stage of the 5-stage MIPS pipeline, directly upstream of the ALU. It latches the decoded instruction and register-file data from ID and decodes the ALU operation code and overflow-enable. Each cycle it resolves EX/MEM and MEM/WB forwarding to drive the ALU's A, B, ALU_Ctr and alu_sign inputs, plus the control that travels on to the EX/MEM register. It supports hold (freeze) and flush (bubble) from the hazard unit.

## Interface
- RESET_PC, 32'h0000_0000, value of ex_pc after reset and in bubbles
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  raw instruction word
- id_pc  in  32  PC of id_instr
- id_rs_data, id_rt_data  in  32 each  register-file read data
- ex_hold  in  1  freeze EX register
- ex_flush  in  1  load bubble into EX register
- mem_fwd_we, mem_fwd_addr, mem_fwd_data  in  1/5/32  EX/MEM result write-back candidate
- wb_fwd_we, wb_fwd_addr, wb_fwd_data  in  1/5/32  MEM/WB write-back candidate
- alu_a, alu_b  out  32  ALU operands
- alu_ctr  out  4  ALU operation code
- alu_sign  out  1  enables ALU overflow reporting
- ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_illegal  out  1 each  EX-stage control
- ex_dst  out  5  destination register
- ex_store_data  out  32  forwarded rt value for sw
- ex_pc  out  32  PC of EX instruction

## Operation
- Stored state: valid, instr, pc, rs_data, rt_data, and decoded control (alu_ctr, alu_sign, src_imm, imm_zext, lui, reg_wr, mem_rd, mem_wr, dst, illegal).
- Immediate: sign-extend instr[15:0]. andi/ori/xori zero-extend it. For lui, B = {instr[15:0],16'h0} and A = 0.
- ALU codes: and 0000, or 0001, add 0010, xor 0011, nor 0100, srl 0101, sub 0110, slt 0111, sll 1000.
- R-type decode (op 000000), listed as funct -> code/sign:
  - add 100000 -> 0010/1; addu 100001 -> 0010/0; sub 100010 -> 0110/1; subu 100011 -> 0110/0
  - and 100100 -> 0000; or 100101 -> 0001; xor 100110 -> 0011; nor 100111 -> 0100; slt 101010 -> 0111 (all sign 0)
  - sll 000000 -> 1000; srl 000010 -> 0101
- R-type: dst = rd, reg_wr = 1. Shifts: A = rt value, B = sign-extended imm (shamt is in B[10:6]).
- I-type decode, listed as op -> code/sign:
  - addi 001000 -> 0010/1; addiu 001001 -> 0010/0; slti 001010 -> 0111
  - andi 001100 -> 0000; ori 001101 -> 0001; xori 001110 -> 0011; lui 001111 -> 0001
  - lw 100011 -> 0010 (mem_rd); sw 101011 -> 0010 (mem_wr, no reg_wr)
  - beq 000100 and bne 000101 -> 0110, no reg_wr, B = rt
- I-type: dst = rt. Sign is 0 unless listed.
- Any other op/funct: illegal = 1, reg_wr = mem_rd = mem_wr = 0, alu_ctr = 0000.
- dst = 0 forces reg_wr = 0.
- Forwarding (combinational, per operand, on stored rs/rt): EX/MEM wins over MEM/WB, which wins over the stored value. A source only matches if its we = 1, its addr equals the operand register, and the register is nonzero.
- ex_store_data is the forwarded rt value.
- Register update priority: rst > ex_flush > ex_hold > load.
  - flush: load bubble (valid 0, all control 0, instr 0, pc RESET_PC).
  - hold: keep instr/control, but write the forwarded rs/rt values back into rs_data/rt_data so forwarded data survives the producer retiring.
  - load: capture ID inputs. If id_valid = 0, load a bubble.
- All control outputs are gated by valid: a bubble drives reg_wr = mem_rd = mem_wr = illegal = alu_sign = 0.

## Timing
- One-cycle latency: an instruction presented at edge N appears on EX outputs after edge N.
- alu_a, alu_b and ex_store_data are combinational from stored state plus the current-cycle fwd inputs, with no added register.
- Reset (asynchronous, immediate): all outputs 0 except ex_pc = RESET_PC. alu_ctr = 0000, ex_valid = 0.
- Reset mid-hold discards the held instruction.
- Flush and hold asserted together: flush wins.
- Sustained hold: outputs stay stable except operand refresh from forwarding. No instruction is duplicated or lost.

## Test plan
- Reset: assert rst between edges -> outputs zero immediately, ex_pc = RESET_PC; release, load add $3,$1,$2 with rs = 5, rt = 7 -> next cycle alu_a = 5, alu_b = 7, alu_ctr = 0010, alu_sign = 1, ex_dst = 3, ex_reg_wr = 1.
- Decode sweep of every listed op/funct -> code/sign as specified. Specific checks:
  - andi imm 16'hFFFF -> B = 32'h0000FFFF
  - addiu imm 16'h8000 -> B = 32'hFFFF8000
  - lui 16'h1234 -> A = 0, B = 32'h12340000
  - sll $2,$1,4 -> A = rt data, B[10:6] = 4
  - unknown op 111111 -> ex_illegal = 1, ex_reg_wr = 0
- Forwarding: rs = $4, mem_fwd (1,4,32'hAAAA) and wb_fwd (1,4,32'hBBBB) -> alu_a = 32'hAAAA. With mem_fwd_we = 0 -> 32'hBBBB. Register $0 with both fwd active -> stored value.
- Hold refresh: hold 3 cycles on sw with rt = $6; wb_fwd (1,6,32'h55) in cycle 1 only -> ex_store_data = 32'h55 in cycles 1-3 and after release.
- Flush/hold priority: ex_flush = ex_hold = 1 -> next cycle ex_valid = 0, all write controls 0. id_valid = 0 load -> bubble.
- Destination zero: addi $0,$1,5 -> ex_reg_wr = 0, alu_ctr = 0010.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ID/EX pipeline register and operand-select stage of the 5-stage MIPS pipeline.
// The stage latches the ID instruction and its register-file data. It decodes the
// ALU operation and the overflow enable when the instruction is captured. Each
// cycle it resolves EX/MEM and MEM/WB forwarding to form the ALU operands.
//
// Ports:
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   id_valid/id_instr/id_pc     instruction from ID (valid flag, raw word, PC)
//   id_rs_data/id_rt_data       register-file read data for rs/rt
//   ex_hold/ex_flush            freeze / bubble requests from the hazard unit
//   mem_fwd_*/wb_fwd_*          write-back candidates from EX/MEM and MEM/WB
//   alu_a/alu_b/alu_ctr/alu_sign  ALU operands, operation code, overflow enable
//   ex_valid/ex_reg_wr/ex_mem_rd/ex_mem_wr/ex_illegal/ex_dst  EX control
//   ex_store_data               forwarded rt value for stores
//   ex_pc                       PC of the instruction in EX
module ex_operand_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        ex_hold,
    input  logic        ex_flush,
    input  logic        mem_fwd_we,
    input  logic [4:0]  mem_fwd_addr,
    input  logic [31:0] mem_fwd_data,
    input  logic        wb_fwd_we,
    input  logic [4:0]  wb_fwd_addr,
    input  logic [31:0] wb_fwd_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctr,
    output logic        alu_sign,
    output logic        ex_valid,
    output logic        ex_reg_wr,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_illegal,
    output logic [4:0]  ex_dst,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_pc
);

    // The opcode is fully represented by the decoded control, so only the
    // register fields and the immediate are kept from the instruction word.
    logic        valid_q,    valid_d;
    logic [25:0] instr_q,    instr_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] rs_data_q,  rs_data_d;
    logic [31:0] rt_data_q,  rt_data_d;
    logic [3:0]  alu_ctr_q,  alu_ctr_d;
    logic        alu_sign_q, alu_sign_d;
    logic        src_imm_q,  src_imm_d;
    logic        imm_zext_q, imm_zext_d;
    logic        lui_q,      lui_d;
    logic        reg_wr_q,   reg_wr_d;
    logic        mem_rd_q,   mem_rd_d;
    logic        mem_wr_q,   mem_wr_d;
    logic [4:0]  dst_q,      dst_d;
    logic        illegal_q,  illegal_d;

    // Decode of the incoming ID instruction
    logic [5:0]  id_op, id_funct;
    logic [3:0]  dec_ctr;
    logic        dec_sign, dec_src_imm, dec_zext, dec_lui;
    logic        dec_reg_wr, dec_mem_rd, dec_mem_wr, dec_illegal;
    logic [4:0]  dec_dst;

    assign id_op    = id_instr[31:26];
    assign id_funct = id_instr[5:0];

    always_comb begin
        dec_ctr     = 4'b0000;
        dec_sign    = 1'b0;
        dec_src_imm = 1'b0;
        dec_zext    = 1'b0;
        dec_lui     = 1'b0;
        dec_reg_wr  = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_illegal = 1'b0;
        dec_dst     = id_instr[20:16];
        case (id_op)
            6'b000000: begin
                dec_dst    = id_instr[15:11];
                dec_reg_wr = 1'b1;
                case (id_funct)
                    6'b100000: begin dec_ctr = 4'b0010; dec_sign = 1'b1; end
                    6'b100001: dec_ctr = 4'b0010;
                    6'b100010: begin dec_ctr = 4'b0110; dec_sign = 1'b1; end
                    6'b100011: dec_ctr = 4'b0110;
                    6'b100100: dec_ctr = 4'b0000;
                    6'b100101: dec_ctr = 4'b0001;
                    6'b100110: dec_ctr = 4'b0011;
                    6'b100111: dec_ctr = 4'b0100;
                    6'b101010: dec_ctr = 4'b0111;
                    // Shifts take the shamt through the sign-extended immediate
                    6'b000000: begin dec_ctr = 4'b1000; dec_src_imm = 1'b1; end
                    6'b000010: begin dec_ctr = 4'b0101; dec_src_imm = 1'b1; end
                    default:   dec_illegal = 1'b1;
                endcase
            end
            6'b001000: begin dec_ctr = 4'b0010; dec_sign = 1'b1; dec_src_imm = 1'b1; dec_reg_wr = 1'b1; end
            6'b001001: begin dec_ctr = 4'b0010; dec_src_imm = 1'b1; dec_reg_wr = 1'b1; end
            6'b001010: begin dec_ctr = 4'b0111; dec_src_imm = 1'b1; dec_reg_wr = 1'b1; end
            6'b001100: begin dec_ctr = 4'b0000; dec_src_imm = 1'b1; dec_zext = 1'b1; dec_reg_wr = 1'b1; end
            6'b001101: begin dec_ctr = 4'b0001; dec_src_imm = 1'b1; dec_zext = 1'b1; dec_reg_wr = 1'b1; end
            6'b001110: begin dec_ctr = 4'b0011; dec_src_imm = 1'b1; dec_zext = 1'b1; dec_reg_wr = 1'b1; end
            6'b001111: begin dec_ctr = 4'b0001; dec_src_imm = 1'b1; dec_lui = 1'b1; dec_reg_wr = 1'b1; end
            6'b100011: begin dec_ctr = 4'b0010; dec_src_imm = 1'b1; dec_mem_rd = 1'b1; dec_reg_wr = 1'b1; end
            6'b101011: begin dec_ctr = 4'b0010; dec_src_imm = 1'b1; dec_mem_wr = 1'b1; end
            6'b000100,
            6'b000101: dec_ctr = 4'b0110;
            default:   dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctr    = 4'b0000;
            dec_sign   = 1'b0;
            dec_reg_wr = 1'b0;
            dec_mem_rd = 1'b0;
            dec_mem_wr = 1'b0;
        end
        // Writes to $0 are architecturally discarded
        if (dec_dst == 5'd0) begin
            dec_reg_wr = 1'b0;
        end
    end

    // Forwarding per operand: index 0 = rs, index 1 = rt
    logic [4:0]  src_addr [2];
    logic [31:0] src_data [2];
    logic [31:0] fwd_val  [2];

    assign src_addr[0] = instr_q[25:21];
    assign src_addr[1] = instr_q[20:16];
    assign src_data[0] = rs_data_q;
    assign src_data[1] = rt_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit, wb_hit;
            assign mem_hit = mem_fwd_we && (mem_fwd_addr == src_addr[gi]) && (src_addr[gi] != 5'd0);
            assign wb_hit  = wb_fwd_we  && (wb_fwd_addr  == src_addr[gi]) && (src_addr[gi] != 5'd0);
            assign fwd_val[gi] = mem_hit ? mem_fwd_data : (wb_hit ? wb_fwd_data : src_data[gi]);
        end
    endgenerate

    // Next-state: flush > hold > load (a load with id_valid = 0 is a bubble)
    logic load_bubble, load_new;
    assign load_bubble = ex_flush || (!ex_hold && !id_valid);
    assign load_new    = !ex_flush && !ex_hold && id_valid;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        alu_ctr_d  = alu_ctr_q;
        alu_sign_d = alu_sign_q;
        src_imm_d  = src_imm_q;
        imm_zext_d = imm_zext_q;
        lui_d      = lui_q;
        reg_wr_d   = reg_wr_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        dst_d      = dst_q;
        illegal_d  = illegal_q;
        if (load_bubble) begin
            valid_d    = 1'b0;
            instr_d    = '0;
            pc_d       = RESET_PC;
            rs_data_d  = '0;
            rt_data_d  = '0;
            alu_ctr_d  = 4'b0000;
            alu_sign_d = 1'b0;
            src_imm_d  = 1'b0;
            imm_zext_d = 1'b0;
            lui_d      = 1'b0;
            reg_wr_d   = 1'b0;
            mem_rd_d   = 1'b0;
            mem_wr_d   = 1'b0;
            dst_d      = 5'd0;
            illegal_d  = 1'b0;
        end else if (load_new) begin
            valid_d    = 1'b1;
            instr_d    = id_instr[25:0];
            pc_d       = id_pc;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            alu_ctr_d  = dec_ctr;
            alu_sign_d = dec_sign;
            src_imm_d  = dec_src_imm;
            imm_zext_d = dec_zext;
            lui_d      = dec_lui;
            reg_wr_d   = dec_reg_wr;
            mem_rd_d   = dec_mem_rd;
            mem_wr_d   = dec_mem_wr;
            dst_d      = dec_dst;
            illegal_d  = dec_illegal;
        end else begin
            // Hold: capture forwarded operands so they survive the producer retiring
            rs_data_d = fwd_val[0];
            rt_data_d = fwd_val[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_q       <= RESET_PC;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            alu_ctr_q  <= 4'b0000;
            alu_sign_q <= 1'b0;
            src_imm_q  <= 1'b0;
            imm_zext_q <= 1'b0;
            lui_q      <= 1'b0;
            reg_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            dst_q      <= 5'd0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            alu_ctr_q  <= alu_ctr_d;
            alu_sign_q <= alu_sign_d;
            src_imm_q  <= src_imm_d;
            imm_zext_q <= imm_zext_d;
            lui_q      <= lui_d;
            reg_wr_q   <= reg_wr_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            dst_q      <= dst_d;
            illegal_q  <= illegal_d;
        end
    end

    // Operand select
    logic [31:0] imm_ext;
    logic        shift_op;
    assign imm_ext  = imm_zext_q ? {16'h0000, instr_q[15:0]} : {{16{instr_q[15]}}, instr_q[15:0]};
    // sll/srl are the only instructions decoding to these codes
    assign shift_op = (alu_ctr_q == 4'b1000) || (alu_ctr_q == 4'b0101);

    assign alu_a = lui_q ? 32'h0 : (shift_op ? fwd_val[1] : fwd_val[0]);
    assign alu_b = lui_q ? {instr_q[15:0], 16'h0000} : (src_imm_q ? imm_ext : fwd_val[1]);

    assign alu_ctr       = valid_q ? alu_ctr_q : 4'b0000;
    assign alu_sign      = valid_q && alu_sign_q;
    assign ex_valid      = valid_q;
    assign ex_reg_wr     = valid_q && reg_wr_q;
    assign ex_mem_rd     = valid_q && mem_rd_q;
    assign ex_mem_wr     = valid_q && mem_wr_q;
    assign ex_illegal    = valid_q && illegal_q;
    assign ex_dst        = dst_q;
    assign ex_store_data = fwd_val[1];
    assign ex_pc         = pc_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_rs_data, id_rt_data;
    logic        ex_hold, ex_flush;
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_addr, wb_fwd_addr;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctr;
    logic        alu_sign, ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_illegal;
    logic [4:0]  ex_dst;
    logic [31:0] ex_store_data, ex_pc;

    int n_cmp = 0;
    int n_bad = 0;

    ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .ex_hold(ex_hold), .ex_flush(ex_flush),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_sign(alu_sign),
        .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_illegal(ex_illegal), .ex_dst(ex_dst),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_t(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] pc);
        id_valid   = 1'b1;
        id_instr   = instr;
        id_rs_data = rs;
        id_rt_data = rt;
        id_pc      = pc;
        tick();
    endtask

    task automatic dec(input string tag, input logic [31:0] instr, input logic [3:0] ctr,
                       input logic sign, input logic rw, input logic mr, input logic mw,
                       input logic ill);
        load(instr, 32'h1, 32'h2, 32'h400);
        $display("decode %s instr=%h ctr=%b sign=%b rw=%b", tag, instr, alu_ctr, alu_sign, ex_reg_wr);
        check({tag, ".ctr"},   alu_ctr, ctr);
        check({tag, ".sign"},  alu_sign, sign);
        check({tag, ".rw"},    ex_reg_wr, rw);
        check({tag, ".mrd"},   ex_mem_rd, mr);
        check({tag, ".mwr"},   ex_mem_wr, mw);
        check({tag, ".ill"},   ex_illegal, ill);
        check({tag, ".valid"}, ex_valid, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_instr = '0; id_pc = '0; id_rs_data = '0; id_rt_data = '0;
        ex_hold = 1'b0; ex_flush = 1'b0;
        mem_fwd_we = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
        wb_fwd_we = 1'b0; wb_fwd_addr = '0; wb_fwd_data = '0;
        #3;
        $display("reset state: valid=%b pc=%h", ex_valid, ex_pc);
        check("rst.valid", ex_valid, 1'b0);
        check("rst.pc",    ex_pc, 32'h0);
        check("rst.ctr",   alu_ctr, 4'b0000);
        check("rst.alu_a", alu_a, 32'h0);
        check("rst.alu_b", alu_b, 32'h0);
        check("rst.rw",    ex_reg_wr, 1'b0);
        rst = 1'b0;

        // add $3,$1,$2
        load(r_t(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 32'h100);
        $display("add: a=%h b=%h ctr=%b dst=%0d", alu_a, alu_b, alu_ctr, ex_dst);
        check("add.a",    alu_a, 32'd5);
        check("add.b",    alu_b, 32'd7);
        check("add.ctr",  alu_ctr, 4'b0010);
        check("add.sign", alu_sign, 1'b1);
        check("add.dst",  ex_dst, 5'd3);
        check("add.rw",   ex_reg_wr, 1'b1);
        check("add.pc",   ex_pc, 32'h100);

        // asynchronous reset between edges, while holding
        ex_hold = 1'b1;
        #2 rst = 1'b1;
        #1;
        $display("mid-cycle reset: valid=%b rw=%b pc=%h", ex_valid, ex_reg_wr, ex_pc);
        check("arst.valid", ex_valid, 1'b0);
        check("arst.rw",    ex_reg_wr, 1'b0);
        check("arst.a",     alu_a, 32'h0);
        check("arst.pc",    ex_pc, 32'h0);
        rst = 1'b0;
        tick();
        $display("hold after reset: valid=%b", ex_valid);
        check("arst_hold.valid", ex_valid, 1'b0);
        ex_hold = 1'b0;

        // decode sweep
        dec("add",   r_t(1, 2, 3, 0, 6'h20), 4'b0010, 1, 1, 0, 0, 0);
        dec("addu",  r_t(1, 2, 3, 0, 6'h21), 4'b0010, 0, 1, 0, 0, 0);
        dec("sub",   r_t(1, 2, 3, 0, 6'h22), 4'b0110, 1, 1, 0, 0, 0);
        dec("subu",  r_t(1, 2, 3, 0, 6'h23), 4'b0110, 0, 1, 0, 0, 0);
        dec("and",   r_t(1, 2, 3, 0, 6'h24), 4'b0000, 0, 1, 0, 0, 0);
        dec("or",    r_t(1, 2, 3, 0, 6'h25), 4'b0001, 0, 1, 0, 0, 0);
        dec("xor",   r_t(1, 2, 3, 0, 6'h26), 4'b0011, 0, 1, 0, 0, 0);
        dec("nor",   r_t(1, 2, 3, 0, 6'h27), 4'b0100, 0, 1, 0, 0, 0);
        dec("slt",   r_t(1, 2, 3, 0, 6'h2A), 4'b0111, 0, 1, 0, 0, 0);
        dec("sll",   r_t(0, 1, 2, 4, 6'h00), 4'b1000, 0, 1, 0, 0, 0);
        dec("srl",   r_t(0, 1, 2, 4, 6'h02), 4'b0101, 0, 1, 0, 0, 0);
        dec("badfn", r_t(1, 2, 3, 0, 6'h3F), 4'b0000, 0, 0, 0, 0, 1);
        dec("addi",  i_t(6'h08, 1, 2, 16'h5),    4'b0010, 1, 1, 0, 0, 0);
        dec("addiu", i_t(6'h09, 1, 2, 16'h8000), 4'b0010, 0, 1, 0, 0, 0);
        check("addiu.b", alu_b, 32'hFFFF8000);
        dec("slti",  i_t(6'h0A, 1, 2, 16'h5),    4'b0111, 0, 1, 0, 0, 0);
        dec("andi",  i_t(6'h0C, 1, 2, 16'hFFFF), 4'b0000, 0, 1, 0, 0, 0);
        check("andi.b", alu_b, 32'h0000FFFF);
        dec("ori",   i_t(6'h0D, 1, 2, 16'h8001), 4'b0001, 0, 1, 0, 0, 0);
        check("ori.b", alu_b, 32'h00008001);
        dec("xori",  i_t(6'h0E, 1, 2, 16'h8002), 4'b0011, 0, 1, 0, 0, 0);
        check("xori.b", alu_b, 32'h00008002);
        dec("lui",   i_t(6'h0F, 1, 2, 16'h1234), 4'b0001, 0, 1, 0, 0, 0);
        check("lui.a", alu_a, 32'h0);
        check("lui.b", alu_b, 32'h12340000);
        dec("lw",    i_t(6'h23, 1, 2, 16'h10), 4'b0010, 0, 1, 1, 0, 0);
        check("lw.b", alu_b, 32'h10);
        dec("sw",    i_t(6'h2B, 1, 2, 16'h10), 4'b0010, 0, 0, 0, 1, 0);
        dec("beq",   i_t(6'h04, 1, 2, 16'h10), 4'b0110, 0, 0, 0, 0, 0);
        check("beq.b", alu_b, 32'h2);
        dec("bne",   i_t(6'h05, 1, 2, 16'h10), 4'b0110, 0, 0, 0, 0, 0);
        dec("badop", i_t(6'h3F, 1, 2, 16'h10), 4'b0000, 0, 0, 0, 0, 1);

        // sll $2,$1,4 operand shape: A = rt data, B = sign-extended instr[15:0]
        load(r_t(0, 1, 2, 4, 6'h00), 32'h99, 32'h11, 32'h500);
        $display("sll: a=%h b=%h dst=%0d", alu_a, alu_b, ex_dst);
        check("sll.a",   alu_a, 32'h11);
        check("sll.b",   alu_b, 32'h00001100);
        check("sll.dst", ex_dst, 5'd2);

        // forwarding on rs = $4
        load(r_t(4, 5, 9, 0, 6'h20), 32'h1, 32'h2, 32'h600);
        mem_fwd_we = 1'b1; mem_fwd_addr = 5'd4; mem_fwd_data = 32'hAAAA;
        wb_fwd_we  = 1'b1; wb_fwd_addr  = 5'd4; wb_fwd_data  = 32'hBBBB;
        #1;
        $display("fwd both: a=%h b=%h", alu_a, alu_b);
        check("fwd.mem_wins", alu_a, 32'hAAAA);
        check("fwd.b_untouched", alu_b, 32'h2);
        mem_fwd_we = 1'b0;
        #1;
        $display("fwd wb only: a=%h", alu_a);
        check("fwd.wb", alu_a, 32'hBBBB);
        mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;
        #1;
        check("fwd.none", alu_a, 32'h1);

        // register $0 never forwards
        load(r_t(0, 5, 9, 0, 6'h20), 32'h77, 32'h2, 32'h700);
        mem_fwd_we = 1'b1; mem_fwd_addr = 5'd0; mem_fwd_data = 32'hAAAA;
        wb_fwd_we  = 1'b1; wb_fwd_addr  = 5'd0; wb_fwd_data  = 32'hBBBB;
        #1;
        $display("fwd r0: a=%h", alu_a);
        check("fwd.r0", alu_a, 32'h77);
        mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;

        // hold refresh: sw $6,8($1)
        load(i_t(6'h2B, 1, 6, 16'h8), 32'h1000, 32'h11, 32'h800);
        check("sw.store0", ex_store_data, 32'h11);
        ex_hold = 1'b1;
        id_instr = r_t(1, 2, 3, 0, 6'h20); id_rs_data = 32'd5; id_rt_data = 32'd7; id_pc = 32'h900;
        wb_fwd_we = 1'b1; wb_fwd_addr = 5'd6; wb_fwd_data = 32'h55;
        #1;
        $display("hold c1: store=%h", ex_store_data);
        check("hold.c1.store", ex_store_data, 32'h55);
        tick();
        wb_fwd_we = 1'b0;
        #1;
        $display("hold c2: store=%h pc=%h", ex_store_data, ex_pc);
        check("hold.c2.store", ex_store_data, 32'h55);
        check("hold.c2.mwr",   ex_mem_wr, 1'b1);
        check("hold.c2.pc",    ex_pc, 32'h800);
        tick();
        $display("hold c3: store=%h a=%h b=%h", ex_store_data, alu_a, alu_b);
        check("hold.c3.store", ex_store_data, 32'h55);
        check("hold.c3.a",     alu_a, 32'h1000);
        check("hold.c3.b",     alu_b, 32'h8);
        ex_hold = 1'b0;
        #1;
        check("hold.rel.store", ex_store_data, 32'h55);
        check("hold.rel.pc",    ex_pc, 32'h800);
        tick();
        $display("after hold: pc=%h dst=%0d b=%h", ex_pc, ex_dst, alu_b);
        check("post_hold.pc",  ex_pc, 32'h900);
        check("post_hold.dst", ex_dst, 5'd3);
        check("post_hold.b",   alu_b, 32'd7);
        check("post_hold.mwr", ex_mem_wr, 1'b0);

        // flush and hold together: flush wins
        load(i_t(6'h2B, 1, 2, 16'h4), 32'h1, 32'h2, 32'hA00);
        ex_flush = 1'b1; ex_hold = 1'b1;
        tick();
        $display("flush+hold: valid=%b mwr=%b pc=%h", ex_valid, ex_mem_wr, ex_pc);
        check("flush.valid", ex_valid, 1'b0);
        check("flush.mwr",   ex_mem_wr, 1'b0);
        check("flush.rw",    ex_reg_wr, 1'b0);
        check("flush.pc",    ex_pc, 32'h0);
        ex_flush = 1'b0; ex_hold = 1'b0;

        // id_valid = 0 loads a bubble
        load(r_t(1, 2, 3, 0, 6'h20), 32'h1, 32'h2, 32'hB00);
        check("pre_bubble.valid", ex_valid, 1'b1);
        id_valid = 1'b0;
        tick();
        $display("id bubble: valid=%b rw=%b sign=%b", ex_valid, ex_reg_wr, alu_sign);
        check("bubble.valid", ex_valid, 1'b0);
        check("bubble.rw",    ex_reg_wr, 1'b0);
        check("bubble.sign",  alu_sign, 1'b0);
        check("bubble.pc",    ex_pc, 32'h0);

        // addi $0,$1,5
        load(i_t(6'h08, 1, 0, 16'h5), 32'h1, 32'h2, 32'hC00);
        $display("addi r0: rw=%b ctr=%b dst=%0d", ex_reg_wr, alu_ctr, ex_dst);
        check("dst0.rw",  ex_reg_wr, 1'b0);
        check("dst0.ctr", alu_ctr, 4'b0010);
        check("dst0.dst", ex_dst, 5'd0);
        check("dst0.b",   alu_b, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
